// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   2-way set-associative branch target buffer for the fetch stage.
//   Lookup is combinational from the registered arrays. Updates come from
//   EX/MEM taken branches and jumps. A per-set LRU bit picks the victim way.
//
// Optional feature macro: BTB_STATS_EN
//   When defined, the lookup_count/hit_count ports and their saturating
//   16-bit counters are present. When undefined, they are absent and
//   lookup_valid is ignored.
//
// Ports
//   clk, reset      clock; synchronous active-high reset (clears valid/lru)
//   pc_in           fetch PC being looked up
//   lookup_valid    fetch issuing pc_in this cycle (stats only)
//   ex_mem_pc_in    PC of the resolved control-flow instruction
//   update_btb      resolved branch/jump present in EX/MEM
//   actual_taken    resolved direction
//   branch_target   resolved target address
//   flush_btb       invalidate all entries (fence.i)
//   btb_hit         pc_in matches a valid entry
//   btb_target      target of the hitting way, 0 on miss
//   lookup_count    saturating lookup counter (BTB_STATS_EN only)
//   hit_count       saturating hit counter (BTB_STATS_EN only)
module branch_target_buffer #(
  parameter int SETS  = 8,
  parameter int INDEX = 3,
  parameter int PCW   = 12,
  parameter int TAGW  = PCW - INDEX - 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [PCW-1:0] pc_in,
  input  logic           lookup_valid,
  input  logic [PCW-1:0] ex_mem_pc_in,
  input  logic           update_btb,
  input  logic           actual_taken,
  input  logic [PCW-1:0] branch_target,
  input  logic           flush_btb,
  output logic           btb_hit,
  output logic [PCW-1:0] btb_target
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]    lookup_count,
  output logic [15:0]    hit_count
`endif
);

  logic            valid   [SETS][2];
  logic [TAGW-1:0] tags    [SETS][2];
  logic [PCW-1:0]  targets [SETS][2];
  logic            lru     [SETS];

  // Lookup path
  logic [INDEX-1:0] rd_idx;
  logic [TAGW-1:0]  rd_tag;
  logic             rd_match0;
  logic             rd_match1;

  assign rd_idx = pc_in[INDEX+1:2];
  assign rd_tag = pc_in[PCW-1:INDEX+2];

  always_comb begin
    rd_match0  = valid[rd_idx][0] && (tags[rd_idx][0] == rd_tag);
    rd_match1  = valid[rd_idx][1] && (tags[rd_idx][1] == rd_tag);
    btb_hit    = rd_match0 || rd_match1;
    btb_target = '0;
    if (rd_match0)
      btb_target = targets[rd_idx][0];
    else if (rd_match1)
      btb_target = targets[rd_idx][1];
  end

  // Update path: way selection
  logic [INDEX-1:0] wr_idx;
  logic [TAGW-1:0]  wr_tag;
  logic             wr_match0;
  logic             wr_match1;
  logic             wr_way;

  assign wr_idx = ex_mem_pc_in[INDEX+1:2];
  assign wr_tag = ex_mem_pc_in[PCW-1:INDEX+2];

  // Refresh a matching way; otherwise fill an invalid way (way0 first),
  // otherwise evict the LRU victim.
  always_comb begin
    wr_match0 = valid[wr_idx][0] && (tags[wr_idx][0] == wr_tag);
    wr_match1 = valid[wr_idx][1] && (tags[wr_idx][1] == wr_tag);
    if (wr_match0)
      wr_way = 1'b0;
    else if (wr_match1)
      wr_way = 1'b1;
    else if (!valid[wr_idx][0])
      wr_way = 1'b0;
    else if (!valid[wr_idx][1])
      wr_way = 1'b1;
    else
      wr_way = lru[wr_idx];
  end

  // Tags and targets are deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (reset || flush_btb) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s][0] <= 1'b0;
        valid[s][1] <= 1'b0;
        lru[s]      <= 1'b0;
      end
    end else if (update_btb && actual_taken) begin
      valid[wr_idx][wr_way]   <= 1'b1;
      tags[wr_idx][wr_way]    <= wr_tag;
      targets[wr_idx][wr_way] <= branch_target;
      // Pointing LRU at the other way makes repeated identical updates idempotent.
      lru[wr_idx]             <= ~wr_way;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_count <= '0;
      hit_count    <= '0;
    end else if (lookup_valid) begin
      if (lookup_count != '1)
        lookup_count <= lookup_count + 16'd1;
      if (btb_hit && (hit_count != '1))
        hit_count <= hit_count + 16'd1;
    end
  end

  logic [3:0] unused_pc_bits;
  assign unused_pc_bits = {pc_in[1:0], ex_mem_pc_in[1:0]};
`else
  logic [4:0] unused_pc_bits;
  assign unused_pc_bits = {lookup_valid, pc_in[1:0], ex_mem_pc_in[1:0]};
`endif

endmodule
